// File: rtl/mul_unit_if.sv
// Request/result bundle between the core's main FSM and the iterative multiplier.
interface mul_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               signed_op;
  logic               acc_en;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] acc;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result_hi;
  logic [WIDTH-1:0]   result_lo;
  logic               flag_n;
  logic               flag_z;

  modport master (
    output start, signed_op, acc_en, a, b, acc,
    input  busy, done, result_hi, result_lo, flag_n, flag_z
  );

  modport slave (
    input  start, signed_op, acc_en, a, b, acc,
    output busy, done, result_hi, result_lo, flag_n, flag_z
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative radix-2 WIDTHxWIDTH multiplier with optional 2*WIDTH accumulate.
// Sign is handled by multiplying magnitudes and negating the product in FIX.
module mul_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mul_unit_if.slave  bus
);
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             acc_en_q, acc_en_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    res_q, res_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   step_sum;
  logic [W2-1:0]    prod, prod_signed, fix_res;
  logic             load;

  // Operand magnitudes; 0x8000_0000 maps to 2^(W-1), which fits unsigned.
  assign mag_a = (bus.signed_op && bus.a[WIDTH-1]) ? WIDTH'(-bus.a) : bus.a;
  assign mag_b = (bus.signed_op && bus.b[WIDTH-1]) ? WIDTH'(-bus.b) : bus.b;

  assign step_sum    = {1'b0, part_q} + {1'b0, {WIDTH{mplier_q[0]}} & mcand_q};
  assign prod        = {part_q, mplier_q};
  assign prod_signed = neg_q ? W2'(-prod) : prod;
  assign fix_res     = acc_en_q ? W2'(prod_signed + acc_q) : prod_signed;

  always_comb begin
    state_d  = state_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    part_d   = part_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    acc_en_d = acc_en_q;
    acc_d    = acc_q;
    res_d    = res_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        busy_d   = 1'b1;
        part_d   = step_sum[WIDTH:1];
        mplier_d = {step_sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_d    = fix_res;
        flag_n_d = fix_res[W2-1];
        flag_z_d = (fix_res == '0);
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture operands; results stay untouched until the next FIX.
    if (load) begin
      mcand_d  = mag_a;
      mplier_d = mag_b;
      part_d   = '0;
      cnt_d    = '0;
      neg_d    = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      acc_en_d = bus.acc_en;
      acc_d    = bus.acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      acc_en_q <= 1'b0;
      acc_q    <= '0;
      res_q    <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      part_q   <= part_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      acc_en_q <= acc_en_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_hi = res_q[W2-1:WIDTH];
  assign bus.result_lo = res_q[WIDTH-1:0];
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;
endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: stimulus pushes expected results, a negedge
// monitor pops and compares on every done pulse.
module tb_mul_unit;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  mul_unit_if #(.WIDTH(WIDTH)) bus ();

  mul_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      check("busy_at_done", 64'(bus.busy), 64'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got result %h, expected no done", {bus.result_hi, bus.result_lo});
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result", {bus.result_hi, bus.result_lo}, e);
        check("flags_nz", 64'({bus.flag_n, bus.flag_z}), 64'({e[63], (e == 64'd0)}));
      end
    end
  end

  task automatic set_op(input bit sg, input bit ae, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] acc);
    bus.signed_op = sg;
    bus.acc_en    = ae;
    bus.a         = a;
    bus.b         = b;
    bus.acc       = acc;
  endtask

  // One op from idle; checks latency to done and the busy cycle count.
  task automatic run_op(input string name, input bit sg, input bit ae, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] acc, input logic [63:0] expv);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    set_op(sg, ae, a, b, acc);
    exp_q.push_back(expv);
    lat = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      set_op(1'($urandom), 1'($urandom), $urandom, $urandom, {$urandom, $urandom});
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'd34);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
  endtask

  initial begin
    int dones;
    int last;
    int lat;
    bit hold_bad;

    reset = 1'b1;
    bus.start = 1'b0;
    set_op(1'b0, 1'b0, 32'd0, 32'd0, 64'd0);
    repeat (3) @(negedge clk);
    check("reset_result", {bus.result_hi, bus.result_lo}, 64'd0);
    check("reset_ctl", 64'({bus.busy, bus.done, bus.flag_n, bus.flag_z}), 64'd0);
    reset = 1'b0;

    run_op("u_max",      1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001);
    run_op("s_m1x5",     1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0005, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op("s_minxmin",  1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000);
    run_op("s_acc_zero", 1'b1, 1'b1, 32'd3, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4, 64'd0);
    run_op("u_acc_wrap", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_FFFF_FFFD);
    run_op("s_m3x7",     1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("u_acc_mla",  1'b0, 1'b1, 32'd100, 32'd200, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_4E25);

    // Back-to-back with start held high; operands scrambled while running.
    @(negedge clk);
    bus.start = 1'b1;
    set_op(1'b0, 1'b0, 32'h10, 32'h20, 64'd0);
    exp_q.push_back(64'h200);
    dones = 0;
    last = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        if (dones > 1) check("b2b_period", 64'(k - last), 64'd34);
        last = k;
        if (dones == 1) begin
          set_op(1'b0, 1'b0, 32'h1234, 32'h10, 64'd0);
          exp_q.push_back(64'h12340);
        end else if (dones == 2) begin
          set_op(1'b0, 1'b0, 32'hFFFF, 32'hFFFF, 64'd0);
          exp_q.push_back(64'hFFFE_0001);
        end else begin
          bus.start = 1'b0;
          break;
        end
      end else begin
        set_op(1'b0, 1'b0, $urandom, $urandom, 64'd0);
      end
    end
    check("b2b_dones", 64'(dones), 64'd3);

    // Abort mid-run with reset; the aborted op must never complete.
    @(negedge clk);
    bus.start = 1'b1;
    set_op(1'b0, 1'b0, 32'd7, 32'd9, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_result", {bus.result_hi, bus.result_lo}, 64'd0);
    check("abort_ctl", 64'({bus.busy, bus.done, bus.flag_n, bus.flag_z}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_abort", 1'b0, 1'b0, 32'd6, 32'd7, 64'd0, 64'h2A);

    // Result hold while idle and while the next op runs.
    run_op("hold_setup", 1'b0, 1'b0, 32'd2, 32'd3, 64'd0, 64'd6);
    repeat (50) @(negedge clk);
    check("hold_idle", {bus.result_hi, bus.result_lo}, 64'd6);
    @(negedge clk);
    bus.start = 1'b1;
    set_op(1'b0, 1'b0, 32'd5, 32'd5, 64'd0);
    exp_q.push_back(64'd25);
    hold_bad = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if ({bus.result_hi, bus.result_lo} !== 64'd6) hold_bad = 1'b1;
    end
    check("hold_busy", 64'(hold_bad), 64'd0);
    check("hold_latency", 64'(lat), 64'd34);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
